// File: rtl/imem_responder.sv
// Instruction memory responder: boot-loaded word store serving fetch requests with 1-cycle latency.
// Optional IMEM_PARITY_EN macro adds a per-word even-parity bit checked on every in-range fetch.
module imem_responder #(
  parameter int unsigned INSTRUCTION = 32,
  parameter int unsigned ADDRESS     = 32,
  parameter int unsigned DEPTH       = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic [ADDRESS-1:0]     fetch_addr,
  output logic                   fetch_ready,
  output logic                   instr_valid,
  output logic [INSTRUCTION-1:0] instr_out,
  output logic                   addr_err,
  output logic                   parity_err,
  input  logic                   load_we,
  input  logic [ADDRESS-1:0]     load_addr,
  input  logic [INSTRUCTION-1:0] load_data,
  input  logic                   load_done,
  input  logic                   load_start,
  output logic                   boot_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [INSTRUCTION-1:0] NOP = INSTRUCTION'(32'h0000_0013);

  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_next;

  logic [INSTRUCTION-1:0] mem [DEPTH];
  logic [AW-1:0]          load_idx;
  logic [AW-1:0]          fetch_idx;
  logic                   load_ok;
  logic                   fetch_ok;
  logic                   accept;

  // An address is usable only if word-aligned and all bits above the index are zero.
  assign load_idx  = load_addr[AW+1:2];
  assign fetch_idx = fetch_addr[AW+1:2];
  assign load_ok   = (load_addr[1:0] == 2'b00) && (load_addr[ADDRESS-1:AW+2] == '0);
  assign fetch_ok  = (fetch_addr[1:0] == 2'b00) && (fetch_addr[ADDRESS-1:AW+2] == '0);

  assign fetch_ready = (state == RUN);
  assign boot_busy   = (state == BOOT);
  assign accept      = fetch_req && fetch_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT: if (load_done)  state_next = RUN;
      RUN:  if (load_start) state_next = BOOT;
      default: state_next = BOOT;
    endcase
  end

  // Store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == BOOT && load_we && load_ok) mem[load_idx] <= load_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state == BOOT && load_we && load_ok) par_mem[load_idx] <= ^load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (accept) begin
      parity_err <= fetch_ok ? ((^mem[fetch_idx]) != par_mem[fetch_idx]) : 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr_out   <= '0;
      addr_err    <= 1'b0;
    end else begin
      instr_valid <= accept;
      if (accept) begin
        instr_out <= fetch_ok ? mem[fetch_idx] : NOP;
        addr_err  <= !fetch_ok;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder; expected values are hand-computed constants.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        addr_err;
  logic        parity_err;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_start;
  logic        boot_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  imem_responder #(.INSTRUCTION(32), .ADDRESS(32), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr_out(instr_out),
    .addr_err(addr_err), .parity_err(parity_err),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_done(load_done), .load_start(load_start), .boot_busy(boot_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after an edge; outputs from that edge are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req = 0; fetch_addr = '0; load_we = 0; load_addr = '0; load_data = '0;
    load_done = 0; load_start = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    idle();
    fetch_req = 1; fetch_addr = a;
    step();
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    idle();
    load_we = 1; load_addr = a; load_data = d;
    step();
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    check("rst_ready", 32'(fetch_ready), 32'd0);
    check("rst_busy",  32'(boot_busy),   32'd1);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_out",   instr_out,        32'h0);
    check("rst_aerr",  32'(addr_err),    32'd0);
    check("rst_perr",  32'(parity_err),  32'd0);

    for (int i = 0; i < 5; i++) begin
      fetch(32'h0);
      check("boot_ready", 32'(fetch_ready), 32'd0);
      check("boot_valid", 32'(instr_valid), 32'd0);
      check("boot_busy",  32'(boot_busy),   32'd1);
    end

    load(32'h0, 32'h0050_0093);
    load(32'h4, 32'h00A0_0113);
    load(32'h2,   32'hDEAD_BEEF);   // misaligned, would alias word 0
    load(32'h400, 32'hCAFE_F00D);   // out of range, would alias word 0
    idle();
    load_done = 1;
    step();
    check("run_ready", 32'(fetch_ready), 32'd1);
    check("run_busy",  32'(boot_busy),   32'd0);

    fetch(32'h0);
    check("f0_valid", 32'(instr_valid), 32'd1);
    check("f0_out",   instr_out,        32'h0050_0093);
    check("f0_aerr",  32'(addr_err),    32'd0);
    check("f0_perr",  32'(parity_err),  32'd0);
    fetch(32'h4);
    check("f4_valid", 32'(instr_valid), 32'd1);
    check("f4_out",   instr_out,        32'h00A0_0113);
    check("f4_aerr",  32'(addr_err),    32'd0);
    idle();
    step();
    check("hold_valid", 32'(instr_valid), 32'd0);
    check("hold_out",   instr_out,        32'h00A0_0113);

    fetch(32'h2);
    check("mis_valid", 32'(instr_valid), 32'd1);
    check("mis_out",   instr_out,        32'h0000_0013);
    check("mis_aerr",  32'(addr_err),    32'd1);
    fetch(32'h400);
    check("oor_out",   instr_out,        32'h0000_0013);
    check("oor_aerr",  32'(addr_err),    32'd1);

    load(32'h0, 32'hFFFF_FFFF);
    idle();
    load_done = 1;
    step();
    check("run_done_ign", 32'(fetch_ready), 32'd1);
    fetch(32'h0);
    check("runwe_out",  instr_out,     32'h0050_0093);
    check("runwe_aerr", 32'(addr_err), 32'd0);

    idle();
    load_start = 1; fetch_req = 1; fetch_addr = 32'h4;
    step();
    check("ls_valid", 32'(instr_valid), 32'd1);
    check("ls_out",   instr_out,        32'h00A0_0113);
    check("ls_ready", 32'(fetch_ready), 32'd0);
    check("ls_busy",  32'(boot_busy),   32'd1);

    idle();
    load_we = 1; load_addr = 32'h0; load_data = 32'h0000_0073; load_done = 1;
    step();
    check("rl_ready", 32'(fetch_ready), 32'd1);
    fetch(32'h0);
    check("rl_out", instr_out, 32'h0000_0073);

`ifdef IMEM_PARITY_EN
    dut.par_mem[1] = ~dut.par_mem[1];
    fetch(32'h4);
    check("par_perr", 32'(parity_err), 32'd1);
    check("par_out",  instr_out,       32'h00A0_0113);
    fetch(32'h2);
    check("par_aerr_perr", 32'(parity_err), 32'd0);
`else
    fetch(32'h4);
    check("par_perr", 32'(parity_err), 32'd0);
    check("par_out",  instr_out,       32'h00A0_0113);
`endif

    fetch(32'h4);
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    fetch(32'h0);
    rst = 1;
    step();
    rst = 0;
    idle();
    check("mrst_valid", 32'(instr_valid), 32'd0);
    check("mrst_busy",  32'(boot_busy),   32'd1);
    check("mrst_ready", 32'(fetch_ready), 32'd0);
    check("mrst_out",   instr_out,        32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
